// File: rtl/traffic_phase_ctrl.sv
// Multi-phase traffic signal controller with emergency override and
// front-panel editing of the green and yellow interval lengths.
module traffic_phase_ctrl #(
    parameter int NPH     = 2,
    parameter int CLK_DIV = 50_000_000,
    parameter int T_G_DEF = 22,
    parameter int T_Y_DEF = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           key_emg,
    input  logic           key_set,
    input  logic           key_up,
    input  logic           key_down,
    input  logic [NPH-1:0] ped_req,
    output logic [NPH-1:0] grn,
    output logic [NPH-1:0] yel,
    output logic [NPH-1:0] red,
    output logic [6:0]     cnt,
    output logic [1:0]     phase,
    output logic [1:0]     mode,
    output logic [2:0]     dbg_state
);

    localparam int TW = $clog2(CLK_DIV);

    typedef enum logic [2:0] {
        RUN_G = 3'd0,
        RUN_Y = 3'd1,
        EMG   = 3'd2,
        SET_G = 3'd3,
        SET_Y = 3'd4
    } state_e;

    state_e         state;
    logic [1:0]     ph;
    logic [6:0]     rem;
    logic [6:0]     t_g;
    logic [6:0]     t_y;
    logic [TW-1:0]  tick_cnt;
    logic           tick;
    logic           in_run;
    logic           in_set;
    logic           ped_hit;
    logic [NPH-1:0] ph_onehot;

    assign tick      = (tick_cnt == TW'(CLK_DIV - 1));
    assign in_run    = (state == RUN_G) || (state == RUN_Y);
    assign in_set    = (state == SET_G) || (state == SET_Y);
    assign dbg_state = state;

    always_comb begin
        ph_onehot = '0;
        for (int i = 0; i < NPH; i++) begin
            ph_onehot[i] = (ph == 2'(i));
        end
    end

    // A crossing request from another phase only shortens a long green.
    assign ped_hit = (state == RUN_G) && (|(ped_req & ~ph_onehot)) && (rem > 7'd5);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN_G;
            ph       <= 2'd0;
            rem      <= 7'(T_G_DEF);
            t_g      <= 7'(T_G_DEF);
            t_y      <= 7'(T_Y_DEF);
            tick_cnt <= '0;
            grn      <= '0;
            yel      <= '0;
            red      <= '1;
            cnt      <= 7'd0;
            phase    <= 2'd0;
            mode     <= 2'd0;
        end else begin
            // Lamp and display registers reflect the state held before this edge.
            grn   <= '0;
            yel   <= '0;
            red   <= '1;
            cnt   <= rem;
            phase <= ph;
            mode  <= 2'd0;
            case (state)
                RUN_G: begin
                    grn <= ph_onehot;
                    red <= ~ph_onehot;
                end
                RUN_Y: begin
                    red <= ~ph_onehot;
                    if (tick_cnt < TW'(CLK_DIV / 2)) yel <= ph_onehot;
                end
                EMG: begin
                    cnt  <= 7'd99;
                    mode <= 2'd1;
                end
                SET_G: begin
                    cnt  <= t_g;
                    mode <= 2'd2;
                end
                SET_Y: begin
                    cnt  <= t_y;
                    mode <= 2'd3;
                end
                default: ;
            endcase

            tick_cnt <= tick ? '0 : tick_cnt + TW'(1);

            if (key_emg) begin
                tick_cnt <= '0;
                if (state == EMG) begin
                    state <= RUN_G;
                    ph    <= 2'd0;
                    rem   <= t_g;
                end else begin
                    state <= EMG;
                end
            end else if (key_set && state != EMG) begin
                tick_cnt <= '0;
                if (state == SET_G) begin
                    state <= SET_Y;
                end else if (state == SET_Y) begin
                    state <= RUN_G;
                    ph    <= 2'd0;
                    rem   <= t_g;
                end else begin
                    state <= SET_G;
                end
            end else if (key_up && in_set) begin
                if (state == SET_G) t_g <= (t_g >= 7'd99) ? 7'd99 : t_g + 7'd1;
                else                t_y <= (t_y >= 7'd99) ? 7'd99 : t_y + 7'd1;
            end else if (key_down && in_set) begin
                if (state == SET_G) t_g <= (t_g <= 7'd1) ? 7'd1 : t_g - 7'd1;
                else                t_y <= (t_y <= 7'd1) ? 7'd1 : t_y - 7'd1;
            end else if (ped_hit) begin
                rem <= 7'd5;
            end else if (tick && in_run) begin
                if (rem == 7'd1) begin
                    if (state == RUN_G) begin
                        state <= RUN_Y;
                        rem   <= t_y;
                    end else begin
                        state <= RUN_G;
                        ph    <= (ph == 2'(NPH - 1)) ? 2'd0 : ph + 2'd1;
                        rem   <= t_g;
                    end
                end else begin
                    rem <= rem - 7'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Bench for traffic_phase_ctrl: fixed schedule vectors, directed key
// sequences and random key traffic compared against a timeline model.
module tb_traffic_phase_ctrl;

    localparam int NPH = 3;
    localparam int CLK_DIV = 10;
    localparam int T_G = 4;
    localparam int T_Y = 2;
    localparam int K_G = 0, K_Y = 1, K_E = 2, K_SG = 3, K_SY = 4;

    logic       clk, rst_n, key_emg, key_set, key_up, key_down;
    logic [2:0] ped_req, grn, yel, red, dbg_state;
    logic [6:0] cnt;
    logic [1:0] phase, mode;

    traffic_phase_ctrl #(.NPH(NPH), .CLK_DIV(CLK_DIV), .T_G_DEF(T_G), .T_Y_DEF(T_Y)) dut (
        .clk(clk), .rst_n(rst_n), .key_emg(key_emg), .key_set(key_set),
        .key_up(key_up), .key_down(key_down), .ped_req(ped_req),
        .grn(grn), .yel(yel), .red(red), .cnt(cnt), .phase(phase),
        .mode(mode), .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [19:0] exp_q[$];
    logic [2:0]  run_g_code;

    // Model: segment timing derived from the absolute cycle index at which
    // the current light segment began.
    int m_kind, m_ph, m_rem, m_tg, m_ty, m_seg, m_cyc;

    typedef struct packed {
        logic [7:0] at;
        logic [2:0] ped;
        logic [2:0] grn;
        logic [2:0] yel;
        logic [2:0] red;
        logic [6:0] cnt;
        logic [1:0] phase;
        logic [1:0] mode;
    } vec_t;
    vec_t vec[19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, m_cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_kind = K_G; m_ph = 0; m_rem = T_G; m_tg = T_G; m_ty = T_Y;
        m_seg = 0; m_cyc = 0;
    endtask

    function automatic logic [19:0] model_out();
        logic [2:0] me, g, y, r;
        logic [6:0] c;
        logic [1:0] md;
        int pos;
        me = 3'(1 << m_ph);
        pos = (m_cyc - m_seg) % CLK_DIV;
        g = 3'b000; y = 3'b000; r = 3'b111; c = 7'(m_rem); md = 2'd0;
        case (m_kind)
            K_G: begin g = me; r = ~me; end
            K_Y: begin r = ~me; if (pos < CLK_DIV / 2) y = me; end
            K_E: begin c = 7'd99; md = 2'd1; end
            K_SG: begin c = 7'(m_tg); md = 2'd2; end
            default: begin c = 7'(m_ty); md = 2'd3; end
        endcase
        return {g, y, r, c, 2'(m_ph), md};
    endfunction

    task automatic model_advance(input logic e, s, u, d, input logic [2:0] p);
        int old_kind, old_ph;
        logic tick, set_mode;
        tick = ((m_cyc - m_seg) % CLK_DIV) == CLK_DIV - 1;
        set_mode = (m_kind == K_SG) || (m_kind == K_SY);
        old_kind = m_kind; old_ph = m_ph;
        if (e) begin
            if (m_kind == K_E) begin m_kind = K_G; m_ph = 0; m_rem = m_tg; end
            else m_kind = K_E;
        end else if (s && m_kind != K_E) begin
            if (m_kind == K_SG) m_kind = K_SY;
            else if (m_kind == K_SY) begin m_kind = K_G; m_ph = 0; m_rem = m_tg; end
            else m_kind = K_SG;
        end else if (u && set_mode) begin
            if (m_kind == K_SG) m_tg = (m_tg < 99) ? m_tg + 1 : 99;
            else m_ty = (m_ty < 99) ? m_ty + 1 : 99;
        end else if (d && set_mode) begin
            if (m_kind == K_SG) m_tg = (m_tg > 1) ? m_tg - 1 : 1;
            else m_ty = (m_ty > 1) ? m_ty - 1 : 1;
        end else if (m_kind == K_G && (p & ~3'(1 << m_ph)) != 3'b000 && m_rem > 5) begin
            m_rem = 5;
        end else if (tick && (m_kind == K_G || m_kind == K_Y)) begin
            if (m_rem == 1) begin
                if (m_kind == K_G) begin m_kind = K_Y; m_rem = m_ty; end
                else begin m_kind = K_G; m_ph = (m_ph + 1) % NPH; m_rem = m_tg; end
            end else begin
                m_rem = m_rem - 1;
            end
        end
        if (m_kind != old_kind || m_ph != old_ph) m_seg = m_cyc + 1;
    endtask

    task automatic step(input logic e, s, u, d, input logic [2:0] p);
        logic [19:0] exp_v;
        key_emg = e; key_set = s; key_up = u; key_down = d; ped_req = p;
        exp_q.push_back(model_out());
        model_advance(e, s, u, d, p);
        @(posedge clk); #1;
        m_cyc++;
        exp_v = exp_q.pop_front();
        chk("cycle_outputs", {12'd0, grn, yel, red, cnt, phase, mode}, {12'd0, exp_v});
        chk("dbg_state_run_g", 32'(dbg_state == run_g_code), 32'(m_kind == K_G));
        key_emg = 1'b0; key_set = 1'b0; key_up = 1'b0; key_down = 1'b0; ped_req = 3'b000;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
    endtask

    task automatic check_reset_vals(input string name);
        chk(name, {12'd0, grn, yel, red, cnt, phase, mode},
            {12'd0, 3'b000, 3'b000, 3'b111, 7'd0, 2'd0, 2'd0});
    endtask

    task automatic do_reset();
        key_emg = 1'b0; key_set = 1'b0; key_up = 1'b0; key_down = 1'b0; ped_req = 3'b000;
        rst_n = 1'b0;
        #1;
        check_reset_vals("reset_async");
        @(posedge clk); #1;
        check_reset_vals("reset_hold");
        rst_n = 1'b1;
        model_reset();
        exp_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic e, s, u, d;
        logic [2:0] p;
        int ti;
        vec[0]  = '{8'd0,   3'b000, 3'b001, 3'b000, 3'b110, 7'd4, 2'd0, 2'd0};
        vec[1]  = '{8'd5,   3'b100, 3'b001, 3'b000, 3'b110, 7'd4, 2'd0, 2'd0};
        vec[2]  = '{8'd9,   3'b000, 3'b001, 3'b000, 3'b110, 7'd4, 2'd0, 2'd0};
        vec[3]  = '{8'd10,  3'b000, 3'b001, 3'b000, 3'b110, 7'd3, 2'd0, 2'd0};
        vec[4]  = '{8'd39,  3'b000, 3'b001, 3'b000, 3'b110, 7'd1, 2'd0, 2'd0};
        vec[5]  = '{8'd40,  3'b000, 3'b000, 3'b001, 3'b110, 7'd2, 2'd0, 2'd0};
        vec[6]  = '{8'd44,  3'b000, 3'b000, 3'b001, 3'b110, 7'd2, 2'd0, 2'd0};
        vec[7]  = '{8'd45,  3'b000, 3'b000, 3'b000, 3'b110, 7'd2, 2'd0, 2'd0};
        vec[8]  = '{8'd50,  3'b000, 3'b000, 3'b001, 3'b110, 7'd1, 2'd0, 2'd0};
        vec[9]  = '{8'd59,  3'b000, 3'b000, 3'b000, 3'b110, 7'd1, 2'd0, 2'd0};
        vec[10] = '{8'd60,  3'b000, 3'b010, 3'b000, 3'b101, 7'd4, 2'd1, 2'd0};
        vec[11] = '{8'd65,  3'b001, 3'b010, 3'b000, 3'b101, 7'd4, 2'd1, 2'd0};
        vec[12] = '{8'd69,  3'b000, 3'b010, 3'b000, 3'b101, 7'd4, 2'd1, 2'd0};
        vec[13] = '{8'd70,  3'b000, 3'b010, 3'b000, 3'b101, 7'd3, 2'd1, 2'd0};
        vec[14] = '{8'd100, 3'b000, 3'b000, 3'b010, 3'b101, 7'd2, 2'd1, 2'd0};
        vec[15] = '{8'd120, 3'b000, 3'b100, 3'b000, 3'b011, 7'd4, 2'd2, 2'd0};
        vec[16] = '{8'd160, 3'b000, 3'b000, 3'b100, 3'b011, 7'd2, 2'd2, 2'd0};
        vec[17] = '{8'd175, 3'b000, 3'b000, 3'b000, 3'b011, 7'd1, 2'd2, 2'd0};
        vec[18] = '{8'd180, 3'b000, 3'b001, 3'b000, 3'b110, 7'd4, 2'd0, 2'd0};

        rst_n = 1'b0; key_emg = 1'b0; key_set = 1'b0; key_up = 1'b0; key_down = 1'b0;
        ped_req = 3'b000;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset_por");
        run_g_code = dbg_state;
        rst_n = 1'b1;

        // Full cycle through all three phases with fixed-schedule spot checks.
        ti = 0;
        for (int k = 0; k <= 180; k++) begin
            p = (ti < 19 && int'(vec[ti].at) == k) ? vec[ti].ped : 3'b000;
            step(1'b0, 1'b0, 1'b0, 1'b0, p);
            if (ti < 19 && int'(vec[ti].at) == k) begin
                chk($sformatf("vec_%0d", ti), {12'd0, grn, yel, red, cnt, phase, mode},
                    {12'd0, vec[ti].grn, vec[ti].yel, vec[ti].red, vec[ti].cnt,
                     vec[ti].phase, vec[ti].mode});
                ti++;
            end
        end

        // Emergency entered mid-yellow, then released.
        for (int i = 0; i < 200 && m_kind != K_Y; i++) idle(1);
        idle(3);
        step(1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
        idle(1);
        chk("emg_mode", mode, 2'd1);
        chk("emg_cnt", cnt, 7'd99);
        chk("emg_red", red, 3'b111);
        chk("emg_grn_yel", {grn, yel}, 6'b000000);
        idle(4);
        step(1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
        for (int i = 0; i <= 10; i++) begin
            idle(1);
            if (i == 0) begin
                chk("emg_exit_cnt", cnt, 7'd4);
                chk("emg_exit_phase", phase, 2'd0);
                chk("emg_exit_grn", grn, 3'b001);
                chk("emg_exit_mode", mode, 2'd0);
            end
            if (i == 9) chk("emg_exit_full_second", cnt, 7'd4);
            if (i == 10) chk("emg_exit_first_tick", cnt, 7'd3);
        end

        // key_emg beats key_set; key_up beats a coincident tick in SET_G.
        step(1'b1, 1'b1, 1'b0, 1'b0, 3'b000);
        idle(1);
        chk("emg_over_set", mode, 2'd1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
        step(1'b0, 1'b1, 1'b0, 1'b0, 3'b000);
        idle(1);
        chk("set_g_enter_mode", mode, 2'd2);
        chk("set_g_enter_cnt", cnt, 7'd4);
        idle(8);
        step(1'b0, 1'b0, 1'b1, 1'b0, 3'b000);
        idle(1);
        chk("up_with_tick_mode", mode, 2'd2);
        chk("up_with_tick_tg", cnt, 7'd5);

        // Raise t_g to 9, then a pedestrian request at remaining=8.
        repeat (4) step(1'b0, 1'b0, 1'b1, 1'b0, 3'b000);
        step(1'b0, 1'b1, 1'b0, 1'b0, 3'b000);
        step(1'b0, 1'b1, 1'b0, 1'b0, 3'b000);
        idle(1);
        chk("new_tg_load", cnt, 7'd9);
        idle(9);
        step(1'b0, 1'b0, 1'b0, 1'b0, 3'b100);
        chk("ped_before", cnt, 7'd8);
        idle(1);
        chk("ped_shortened", cnt, 7'd5);

        // Saturation of both edited times.
        do_reset();
        step(1'b0, 1'b1, 1'b0, 1'b0, 3'b000);
        repeat (5) step(1'b0, 1'b0, 1'b0, 1'b1, 3'b000);
        idle(1);
        chk("tg_sat_mode", mode, 2'd2);
        chk("tg_sat_low", cnt, 7'd1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 3'b000);
        repeat (120) step(1'b0, 1'b0, 1'b1, 1'b0, 3'b000);
        idle(1);
        chk("ty_sat_mode", mode, 2'd3);
        chk("ty_sat_high", cnt, 7'd99);
        step(1'b0, 1'b1, 1'b0, 1'b0, 3'b000);
        idle(1);
        chk("set_exit_mode", mode, 2'd0);
        chk("set_exit_cnt", cnt, 7'd1);
        chk("set_exit_grn", {grn, phase}, {3'b001, 2'd0});

        // Reset during SET_Y discards the edits.
        step(1'b0, 1'b1, 1'b0, 1'b0, 3'b000);
        step(1'b0, 1'b0, 1'b1, 1'b0, 3'b000);
        step(1'b0, 1'b1, 1'b0, 1'b0, 3'b000);
        step(1'b0, 1'b0, 1'b0, 1'b1, 3'b000);
        idle(1);
        chk("edit_ty_before_reset", {mode, cnt}, {2'd3, 7'd98});
        do_reset();
        idle(1);
        chk("post_reset_tg", {grn, cnt}, {3'b001, 7'd4});
        for (int i = 0; i < 200 && m_kind != K_Y; i++) idle(1);
        idle(1);
        chk("post_reset_ty", {yel, cnt}, {3'b001, 7'd2});

        // Random key traffic against the model, with one reset midway.
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            e = ($urandom_range(0, 199) == 0);
            s = ($urandom_range(0, 59) == 0);
            u = ($urandom_range(0, 7) == 0);
            d = ($urandom_range(0, 7) == 0);
            p = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            step(e, s, u, d, p);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/traffic_phase_ctrl.md
TRAFFIC_PHASE_CTRL -- requirements
Module: traffic_phase_ctrl

Interface
REQ-001 The block SHALL have parameter NPH, default 2, giving the number of signal phases (legal range 2..4).
REQ-002 The block SHALL have parameter CLK_DIV, default 50_000_000, giving the clk cycles per 1 s tick (even, >=4).
REQ-003 The block SHALL have parameter T_G_DEF, default 22, giving the reset green time in seconds.
REQ-004 The block SHALL have parameter T_Y_DEF, default 3, giving the reset yellow time in seconds.
REQ-005 clk  in  1  system clock; one clock, all logic on its rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 key_emg  in  1  debounced single-cycle pulse: toggle emergency.
REQ-008 key_set  in  1  debounced single-cycle pulse: enter or advance set mode.
REQ-009 key_up  in  1  debounced single-cycle pulse: increment the edited time.
REQ-010 key_down  in  1  debounced single-cycle pulse: decrement the edited time.
REQ-011 ped_req  in  NPH  per-phase pedestrian request pulses.
REQ-012 grn / yel / red  out  NPH each  per-phase lamp drives, registered.
REQ-013 cnt  out  7  binary value for display, registered.
REQ-014 phase  out  2  index of the active phase, registered.
REQ-015 mode  out  2  0=RUN, 1=EMG, 2=SET_G, 3=SET_Y; registered.

Function
REQ-016 The state machine SHALL have states RUN_G, RUN_Y, EMG, SET_G, SET_Y; the tick counter SHALL count 0..CLK_DIV-1, raise tick at CLK_DIV-1, and clear on every state or phase change.
REQ-017 RUN_G SHALL drive grn[phase]=1, red=1 for all other phases, and yel=0.
REQ-018 RUN_Y SHALL drive yel[phase]=1 while the tick counter is < CLK_DIV/2 (else 0), with red=1 for all other phases.
REQ-019 On entry to RUN_G or RUN_Y the remaining-time register SHALL load t_g or t_y; each tick SHALL decrement it, and a tick with value 1 SHALL end the interval instead.
REQ-020 An interval ending in RUN_G SHALL move to RUN_Y for the same phase.
REQ-021 An interval ending in RUN_Y SHALL move to RUN_G with phase=(phase+1) mod NPH.
REQ-022 In RUN_G, ped_req[i] for any i != phase with remaining > 5 SHALL set remaining to 5; otherwise the request SHALL be ignored.
REQ-023 In RUN states cnt SHALL equal remaining.
REQ-024 In EMG, cnt SHALL be 99, all red=1, all grn=0, and all yel=0.
REQ-025 In SET_G / SET_Y, cnt SHALL be t_g / t_y respectively, with all red=1.
REQ-026 key_emg from RUN, SET_G or SET_Y SHALL enter EMG.
REQ-027 key_emg in EMG SHALL enter RUN_G with phase 0 and remaining=t_g.
REQ-028 key_set from RUN SHALL enter SET_G; key_set in SET_G SHALL enter SET_Y; key_set in SET_Y SHALL enter RUN_G with phase 0 and the new t_g.
REQ-029 key_set SHALL be ignored in EMG.
REQ-030 In set states, key_up / key_down SHALL adjust the edited time by ±1, saturating within 1..99; t_g and t_y SHALL be 7-bit.
REQ-031 Same-cycle priority SHALL be key_emg > key_set > key_up > key_down > ped_req > tick.
REQ-032 Edited times SHALL be retained through EMG and SHALL take effect only at the next interval load.
REQ-033 Outputs SHALL follow the state with exactly one clk of latency.

Reset
REQ-034 While rst_n=0: state=RUN_G, phase=0, remaining=T_G_DEF, t_g=T_G_DEF, t_y=T_Y_DEF, tick counter=0, grn=0, yel=0, red=all 1s, cnt=0, mode=0.
REQ-035 Reset asserted mid-operation SHALL abandon any set or emergency state immediately; edits SHALL be lost.

Verification (NPH=3, CLK_DIV=10, T_G_DEF=4, T_Y_DEF=2)
REQ-036 Release reset, run 180 cycles -> grn[0] for 40 cycles with cnt 4,3,2,1; then yel[0] blinking 5 on / 5 off for 20 cycles; then phase 1, then phase 2, then back to phase 0.
REQ-037 ped_req[2] at remaining=4 in phase 0 -> no change; set t_g=9 and repeat at remaining=8 -> cnt=5 the next cycle.
REQ-038 key_emg mid RUN_Y -> mode=1, cnt=99, red=3'b111; key_emg again -> RUN_G, phase=0, cnt=4, full 10-cycle first second.
REQ-039 key_set, key_down ×5 -> t_g saturates at 1; key_set, key_up ×120 -> t_y=99; key_set -> RUN_G with cnt=1.
REQ-040 key_emg and key_set in the same cycle during RUN -> EMG; key_up together with tick in SET_G -> t_g+1, no state change.
REQ-041 rst_n low for 1 cycle during SET_Y -> all REQ-034 values; t_y=2 on the next RUN_Y entry.
